// File: rtl/rv32i_reg_dump_if.sv
// rv32i_reg_dump_if: control, register-file read port and beat stream of the register dumper
interface rv32i_reg_dump_if;
  logic        start;
  logic        abort;
  logic        busy;
  logic        done;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_index;
  logic        out_last;
  modport master (
    input  start, abort, rd_data, out_ready,
    output busy, done, rd_addr, out_valid, out_data, out_index, out_last
  );
  modport slave (
    output start, abort, rd_data, out_ready,
    input  busy, done, rd_addr, out_valid, out_data, out_index, out_last
  );
endinterface

// File: rtl/rv32i_reg_dump.sv
// rv32i_reg_dump: walks the register file read port and streams index/value beats with backpressure
module rv32i_reg_dump #(
  parameter int NUM_REGS = 32,
  parameter bit SKIP_X0  = 1'b0
) (
  input logic clk,
  input logic rst,
  rv32i_reg_dump_if.master bus
);
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
  localparam logic [4:0] FIRST = SKIP_X0 ? 5'd1 : 5'd0;
  localparam logic [4:0] LAST  = 5'(NUM_REGS - 1);
  state_t state;
  logic [4:0] idx;
  logic all_read, load, fire;
  assign bus.rd_addr = idx;
  assign fire = bus.out_valid && bus.out_ready;
  // one-deep output register: refill whenever it is empty or being drained
  assign load = state == SEND && !all_read && (!bus.out_valid || bus.out_ready);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= 5'd0;
      all_read      <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= 32'd0;
      bus.out_index <= 5'd0;
      bus.out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          idx      <= FIRST;
          all_read <= 1'b0;
          bus.busy <= 1'b1;
          state    <= SEND;
        end
        SEND: if (bus.abort) begin
          bus.out_valid <= 1'b0;
          bus.busy      <= 1'b0;
          idx           <= 5'd0;
          state         <= IDLE;
        end else begin
          if (load) begin
            bus.out_data  <= bus.rd_data;
            bus.out_index <= idx;
            bus.out_last  <= idx == LAST;
            bus.out_valid <= 1'b1;
            if (idx == LAST) all_read <= 1'b1;
            else idx <= idx + 5'd1;
          end else if (fire) bus.out_valid <= 1'b0;
          if (fire && bus.out_last) begin
            bus.out_valid <= 1'b0;
            bus.done      <= 1'b1;
            state         <= DONE;
          end
        end
        default: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          idx      <= 5'd0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule
